// File: rtl/fsm_result_sink_if.sv
// Host-side half-word stream of fsm_result_sink: data/tag/last under valid/ready.
// Optional out_class lane exists only when FP_CLASSIFY_EN is defined.
interface fsm_result_sink_if;
    logic [15:0] out_data;
    logic [1:0]  out_tag;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
`ifdef FP_CLASSIFY_EN
    logic [2:0]  out_class;

    modport master (
        output out_data, out_tag, out_last, out_valid, out_class,
        input  out_ready
    );

    modport slave (
        input  out_data, out_tag, out_last, out_valid, out_class,
        output out_ready
    );
`else
    modport master (
        output out_data, out_tag, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_tag, out_last, out_valid,
        output out_ready
    );
`endif
endinterface

// File: rtl/fsm_result_sink.sv
// Captures result/error events of the float sequence FSM into a FIFO and streams them
// out as two 16-bit halves (high first). Optional FP_CLASSIFY_EN adds out_class.
module fsm_result_sink #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r_o,
    input  logic [31:0]          res_data,
    input  logic [1:0]           err,
    fsm_result_sink_if.master    bus,
    output logic [PTR_W:0]       fifo_cnt,
    output logic                 overflow,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int ENT_W = 34;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO
    } ser_state_t;

    ser_state_t state_q, state_d;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_addr, rd_addr, nx_addr;

    logic             r_prev;
    logic [1:0]       err_prev;
    logic             res_ev, err_ev, push_req, push_acc, pop;
    logic             full, empty, have_next;
    logic [ENT_W-1:0] push_entry, head, next_head;

    logic [ENT_W-1:0] hold_q, hold_d;
    logic [15:0]      data_q, data_d;
    logic [1:0]       tag_q, tag_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    logic [1:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;

    assign wr_addr = wr_ptr[PTR_W-1:0];
    assign rd_addr = rd_ptr[PTR_W-1:0];
    assign nx_addr = rd_addr + PTR_W'(1);

    assign fifo_cnt = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_addr == rd_addr) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    assign res_ev     = r_o & ~r_prev;
    assign err_ev     = (err != 2'b00) && (err_prev == 2'b00);
    assign push_req   = res_ev | err_ev;
    assign push_entry = err_ev ? {err, 32'h0} : {2'b00, res_data};

    // Valid is always high in LO, so ready alone completes the low-half handshake.
    assign pop      = (state_q == S_LO) && bus.out_ready;
    assign push_acc = push_req && (!full || pop);

    // Entry following the popped head: from memory, or bypassed from a same-cycle push.
    assign head      = mem[rd_addr];
    assign have_next = (fifo_cnt > (PTR_W+1)'(1)) || push_acc;
    assign next_head = (fifo_cnt > (PTR_W+1)'(1)) ? mem[nx_addr] : push_entry;

    assign drop_inc = {1'b0, res_ev & err_ev} + {1'b0, push_req & full & ~pop};
    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_addr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            r_prev   <= 1'b0;
            err_prev <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            r_prev   <= r_o;
            err_prev <= err;
            if (push_acc) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (drop_inc != 2'b00) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        tag_d   = tag_q;
        last_d  = last_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    hold_d  = head;
                    data_d  = head[31:16];
                    tag_d   = head[33:32];
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (bus.out_ready) begin
                    data_d  = hold_q[15:0];
                    last_d  = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (bus.out_ready) begin
                    if (have_next) begin
                        hold_d  = next_head;
                        data_d  = next_head[31:16];
                        tag_d   = next_head[33:32];
                        last_d  = 1'b0;
                        valid_d = 1'b1;
                        state_d = S_HI;
                    end else begin
                        data_d  = '0;
                        tag_d   = '0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

`ifdef FP_CLASSIFY_EN
    function automatic logic [2:0] classify(input logic [ENT_W-1:0] ent);
        logic [7:0]  exp_f;
        logic [22:0] man_f;
        exp_f = ent[30:23];
        man_f = ent[22:0];
        if (ent[33:32] != 2'b00)                 return 3'b111;
        else if (exp_f == 8'h00 && man_f == '0)  return 3'b001;
        else if (exp_f == 8'h00)                 return 3'b010;
        else if (exp_f == 8'hFF && man_f == '0)  return 3'b011;
        else if (exp_f == 8'hFF)                 return 3'b100;
        else                                     return 3'b000;
    endfunction

    // Class follows the hold latch so it stays constant across both halves.
    logic [2:0] class_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            class_q <= '0;
        end else if (hold_d != hold_q || (state_q != S_HI && state_d == S_HI)) begin
            class_q <= classify(hold_d);
        end
    end

    assign bus.out_class = class_q;
`endif

endmodule

// File: tb/tb_fsm_result_sink.sv
// Directed and randomized bench for fsm_result_sink against a queue-based reference model.
module tb_fsm_result_sink;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r_o = 1'b0;
    logic [31:0] res_data = '0;
    logic [1:0]  err = '0;
    logic [3:0]  fifo_cnt;
    logic        overflow;
    logic [7:0]  drop_cnt;

    fsm_result_sink_if bus();

    fsm_result_sink #(.DEPTH(8), .PTR_W(3), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .r_o      (r_o),
        .res_data (res_data),
        .err      (err),
        .bus      (bus),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending entries plus a transmit flag and half selector.
    logic [33:0] q[$];
    bit          m_busy, m_half, m_rprev, m_ovf;
    logic [1:0]  m_eprev;
    int          m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef FP_CLASSIFY_EN
    function automatic logic [2:0] ref_class(input logic [33:0] e);
        if (e[33:32] != 2'b00) return 3'b111;
        if (e[30:23] == 8'h00) return (e[22:0] == 0) ? 3'b001 : 3'b010;
        if (e[30:23] == 8'hFF) return (e[22:0] == 0) ? 3'b011 : 3'b100;
        return 3'b000;
    endfunction
`endif

    task automatic model_clear();
        q.delete();
        m_busy = 0; m_half = 0; m_rprev = 0; m_eprev = 2'b00; m_ovf = 0; m_drop = 0;
    endtask

    task automatic model_edge();
        bit rev, eev, req, pop, was_busy;
        int sz, d;
        logic [33:0] ent;
        rev = r_o && !m_rprev;
        eev = (err != 2'b00) && (m_eprev == 2'b00);
        req = rev || eev;
        ent = eev ? {err, 32'h0} : {2'b00, res_data};
        pop = m_busy && m_half && bus.out_ready;
        sz = q.size();
        was_busy = m_busy;
        d = 0;
        if (rev && eev) d++;
        if (pop) void'(q.pop_front());
        if (req) begin
            if (sz == DEPTH && !pop) d++;
            else q.push_back(ent);
        end
        if (d > 0) m_ovf = 1;
        m_drop = (m_drop + d > 255) ? 255 : m_drop + d;
        if (!was_busy) begin
            if (sz > 0) begin m_busy = 1; m_half = 0; end
        end else if (bus.out_ready) begin
            if (!m_half) m_half = 1;
            else if (q.size() > 0) m_half = 0;
            else m_busy = 0;
        end
        m_rprev = r_o;
        m_eprev = err;
    endtask

    task automatic check_outputs();
        logic [33:0] h;
        check("valid", bus.out_valid, m_busy);
        check("fifo_cnt", fifo_cnt, q.size());
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
        if (m_busy && q.size() > 0) begin
            h = q[0];
            check("data", bus.out_data, m_half ? h[15:0] : h[31:16]);
            check("tag", bus.out_tag, h[33:32]);
            check("last", bus.out_last, m_half);
`ifdef FP_CLASSIFY_EN
            check("class", bus.out_class, ref_class(h));
`endif
        end
    endtask

    task automatic step(input bit r, input logic [31:0] d, input logic [1:0] e, input bit rdy);
        r_o = r; res_data = d; err = e; bus.out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        r_o = 1'b0; err = 2'b00; bus.out_ready = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_cnt", fifo_cnt, 4'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        model_clear();
        @(posedge clk);
        #1;
        check("rst_hold_valid", bus.out_valid, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        model_clear();
        #2;
        do_reset();

        // single result: valid after two edges, 3F80 then 0000
        step(0, 32'h0, 2'b00, 1);
        step(1, 32'h3F800000, 2'b00, 1);
        check("single_lat", bus.out_valid, 1'b0);
        step(1, 32'h3F800000, 2'b00, 1);
        check("single_hi", {bus.out_valid, bus.out_data, bus.out_tag, bus.out_last}, {1'b1, 16'h3F80, 2'b00, 1'b0});
        step(0, 32'h0, 2'b00, 1);
        check("single_lo", {bus.out_data, bus.out_last}, {16'h0000, 1'b1});
        step(0, 32'h0, 2'b00, 1);
        check("single_cnt", fifo_cnt, 4'd0);

        // backpressure
        step(1, 32'h40490FDB, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 2'b00, 0);
            check("bp_hold", {bus.out_valid, bus.out_data}, {1'b1, 16'h4049});
        end
        step(0, 32'h0, 2'b00, 1);
        check("bp_lo", bus.out_data, 16'h0FDB);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 2'b00, 1);

        // error held high yields one entry
        for (int i = 0; i < 4; i++) step(0, 32'h0, 2'b10, 1);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 2'b00, 1);
        check("err_drained", fifo_cnt, 4'd0);

        // overflow: 10 results, no draining
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h1000_0000 + i, 2'b00, 0);
            step(0, 32'h0, 2'b00, 0);
        end
        check("ovf_state", {fifo_cnt, overflow, drop_cnt}, {4'd8, 1'b1, 8'd2});

        // full FIFO: event coincides with the low-half handshake
        step(0, 32'h0, 2'b00, 1);
        step(1, 32'hABCD1234, 2'b00, 1);
        check("full_pop", {fifo_cnt, drop_cnt}, {4'd8, 8'd2});
        for (int i = 0; i < 20; i++) step(0, 32'h0, 2'b00, 1);

        // reset during the low half
        step(1, 32'h12345678, 2'b00, 0);
        step(0, 32'h0, 2'b00, 0);
        step(0, 32'h0, 2'b00, 1);
        check("pre_rst_lo", bus.out_last, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 32'h0, 2'b00, 1);

        // drop counter saturation
        for (int i = 0; i < 270; i++) begin
            step(1, 32'h7F800000 + i, 2'b00, 0);
            step(0, 32'h0, 2'b00, 0);
        end
        check("drop_sat", drop_cnt, 8'hFF);
        do_reset();

        // randomized traffic, including simultaneous result/error events
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            logic [1:0]  e;
            bit          r, rdy;
            d   = $urandom;
            r   = ($urandom_range(0, 2) == 0);
            e   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdy = ($urandom_range(0, 3) != 0);
            if (i % 500 > 400) rdy = 1'b0;
            step(r, d, e, rdy);
        end
        for (int i = 0; i < 30; i++) step(0, 32'h0, 2'b00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
